// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction memory read port, core handshake and fetch status.
// The fetch unit takes the master modport; the core/memory side takes the slave modport.
interface instr_fetch_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 8,
    parameter int DEPTH       = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                   cs;
    logic                   redirect;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    logic                   imem_re;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [CNT_W-1:0]       buf_count;

    modport master (
        input  cs, redirect, redirect_pc, imem_rdata, instr_ready,
        output imem_re, imem_addr, instr, instr_pc, instr_valid, fetch_pc, buf_count
    );

    modport slave (
        output cs, redirect, redirect_pc, imem_rdata, instr_ready,
        input  imem_re, imem_addr, instr, instr_pc, instr_valid, fetch_pc, buf_count
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetch PC, single-outstanding 1-cycle memory read,
// PC-tagged prefetch FIFO and redirect flush toward the execute core.
module instr_fetch #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    INSTR_WIDTH = 8,
    parameter int                    DEPTH       = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input logic          clk,
    input logic          reset,
    instr_fetch_if.master bus
);
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
    logic                   inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0]  tag_q, tag_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [INSTR_WIDTH-1:0] data_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_q   [DEPTH];

    logic           valid;
    logic           pop;
    logic           push;
    logic           issue;
    logic [CNT_W:0] occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy counts the outstanding read as a reserved slot, so a
    // return always has room and the FIFO can never overflow.
    always_comb begin
        valid = (count_q != '0);
        pop   = valid & bus.instr_ready;
        push  = inflight_q & ~bus.redirect;
        occ   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
        issue = bus.cs & ~bus.redirect & ~reset & (occ < DEPTH_C);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = issue;
        tag_d      = tag_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
                tag_d      = fetch_pc_q;
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: every read of it is qualified by count_q.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            data_q[wr_ptr_q] <= bus.imem_rdata;
            pc_q[wr_ptr_q]   <= tag_q;
        end
    end

    assign bus.imem_re     = issue;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.fetch_pc    = fetch_pc_q;
    assign bus.buf_count   = count_q;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? data_q[rd_ptr_q] : '0;
    assign bus.instr_pc    = valid ? pc_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch;
    localparam int AW    = 8;
    localparam int IW    = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    instr_fetch_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) bus ();

    instr_fetch #(
        .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(8'h00)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory with a fixed one-cycle read latency.
    logic [7:0] mem [256];
    logic [7:0] rd_addr = 8'h00;
    always @(posedge clk) if (bus.imem_re) rd_addr <= bus.imem_addr;
    assign bus.imem_rdata = mem[rd_addr];

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] pc;
    } ent_t;

    ent_t       mq[$];
    bit         m_infl;
    logic [7:0] m_tag;
    logic [7:0] m_pc;

    bit         i_cs, i_red, i_rdy, i_rst;
    logic [7:0] i_rpc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_pop();
        return (mq.size() > 0) && i_rdy;
    endfunction

    // A read may start only if the word it will bring back is guaranteed a slot.
    function automatic bit m_re();
        int room_used;
        room_used = mq.size() + int'(m_infl) - int'(m_pop());
        return !i_rst && i_cs && !i_red && (room_used < DEPTH);
    endfunction

    task automatic compare();
        chk("imem_re", bus.imem_re, m_re());
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("fetch_pc", bus.fetch_pc, m_pc);
        chk("buf_count", bus.buf_count, mq.size());
        chk("instr_valid", bus.instr_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("instr", bus.instr, mq[0].d);
            chk("instr_pc", bus.instr_pc, mq[0].pc);
        end
    endtask

    task automatic update();
        bit re;
        if (i_rst) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = 8'h00;
        end else begin
            re = m_re();
            if (m_pop()) void'(mq.pop_front());
            if (m_infl && !i_red) mq.push_back({mem[m_tag], m_tag});
            if (i_red) begin
                mq.delete();
                m_infl = 1'b0;
                m_pc   = i_rpc;
            end else begin
                m_infl = re;
                if (re) begin
                    m_tag = m_pc;
                    m_pc  = m_pc + 8'd1;
                end
            end
        end
    endtask

    task automatic cb(input bit cs, input bit red, input logic [7:0] rpc, input bit rdy, input bit rst);
        @(negedge clk);
        i_cs = cs; i_red = red; i_rpc = rpc; i_rdy = rdy; i_rst = rst;
        bus.cs          = cs;
        bus.redirect    = red;
        bus.redirect_pc = rpc;
        bus.instr_ready = rdy;
        reset           = rst;
        #1;
        compare();
    endtask

    task automatic ce();
        update();
        @(posedge clk);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'(a + 16);
        bus.cs = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 8'h00; bus.instr_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        mq.delete(); m_infl = 1'b0; m_tag = 8'h00; m_pc = 8'h00;

        // Reset state
        cb(1, 0, 8'h00, 1, 1);
        chk("rst_instr", bus.instr, 8'h00);
        chk("rst_instr_pc", bus.instr_pc, 8'h00);
        chk("rst_valid", bus.instr_valid, 1'b0);
        chk("rst_re", bus.imem_re, 1'b0);
        ce();

        // Sequential fetch, two-cycle issue-to-valid latency
        cb(1, 0, 8'h00, 1, 0);
        chk("t1_re0", bus.imem_re, 1'b1);
        chk("t1_addr0", bus.imem_addr, 8'h00);
        ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t1_addr1", bus.imem_addr, 8'h01);
        chk("t1_not_yet_valid", bus.instr_valid, 1'b0);
        ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t1_valid", bus.instr_valid, 1'b1);
        chk("t1_instr0", bus.instr, 8'h10);
        chk("t1_pc0", bus.instr_pc, 8'h00);
        ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t1_instr1", bus.instr, 8'h11);
        chk("t1_pc1", bus.instr_pc, 8'h01);
        ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t1_instr2", bus.instr, 8'h12);
        ce();

        // Back-pressure fills the FIFO, then drains in order
        cb(1, 0, 8'h00, 0, 1); ce();
        for (int k = 0; k < 3; k++) begin cb(1, 0, 8'h00, 0, 0); ce(); end
        cb(1, 0, 8'h00, 0, 0);
        chk("t2_full", bus.buf_count, 2);
        chk("t2_full_no_re", bus.imem_re, 1'b0);
        chk("t2_hold", bus.instr, 8'h10);
        ce();
        cb(1, 0, 8'h00, 0, 0);
        chk("t2_hold2", bus.instr, 8'h10);
        ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t2_drain0", bus.instr, 8'h10);
        chk("t2_refill_re", bus.imem_re, 1'b1);
        ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t2_drain1", bus.instr, 8'h11);
        ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t2_drain2", bus.instr, 8'h12);
        ce();

        // Redirect with a full FIFO
        cb(1, 0, 8'h00, 0, 0); ce();
        cb(1, 1, 8'h40, 0, 0);
        chk("t3_full_before", bus.buf_count, 2);
        ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t3_flush_valid", bus.instr_valid, 1'b0);
        chk("t3_flush_count", bus.buf_count, 0);
        chk("t3_addr", bus.imem_addr, 8'h40);
        chk("t3_re", bus.imem_re, 1'b1);
        ce();
        cb(1, 0, 8'h00, 1, 0); ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t3_instr", bus.instr, 8'h50);
        chk("t3_pc", bus.instr_pc, 8'h40);
        ce();

        // Address wrap after redirect to FE
        cb(1, 1, 8'hFE, 1, 0); ce();
        cb(1, 0, 8'h00, 1, 0); ce();
        cb(1, 0, 8'h00, 1, 0); ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t4_pc_fe", bus.instr_pc, 8'hFE);
        chk("t4_instr_fe", bus.instr, 8'h0E);
        ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t4_pc_ff", bus.instr_pc, 8'hFF);
        ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t4_pc_00", bus.instr_pc, 8'h00);
        chk("t4_instr_00", bus.instr, 8'h10);
        ce();
        cb(1, 0, 8'h00, 1, 0);
        chk("t4_pc_01", bus.instr_pc, 8'h01);
        ce();

        // Fetch pause: in-flight word still lands, FIFO drains, resume is contiguous
        cb(0, 0, 8'h00, 1, 0);
        chk("t5_cs0_re", bus.imem_re, 1'b0);
        ce();
        for (int k = 0; k < 3; k++) begin cb(0, 0, 8'h00, 1, 0); ce(); end
        cb(1, 0, 8'h00, 1, 0);
        chk("t5_drained", bus.instr_valid, 1'b0);
        chk("t5_resume_addr", bus.imem_addr, 8'h04);
        ce();
        for (int k = 0; k < 4; k++) begin cb(1, 0, 8'h00, 1, 0); ce(); end

        // Reset with a full FIFO
        for (int k = 0; k < 3; k++) begin cb(1, 0, 8'h00, 0, 0); ce(); end
        cb(1, 0, 8'h00, 0, 0);
        chk("t6_full", bus.buf_count, 2);
        ce();
        cb(1, 0, 8'h00, 1, 1);
        chk("t6_re_in_reset", bus.imem_re, 1'b0);
        ce();
        cb(1, 0, 8'h00, 1, 1);
        chk("t6_valid", bus.instr_valid, 1'b0);
        chk("t6_count", bus.buf_count, 0);
        chk("t6_fetch_pc", bus.fetch_pc, 8'h00);
        chk("t6_re", bus.imem_re, 1'b0);
        ce();

        // Randomized traffic against the model
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        for (int n = 0; n < 4000; n++) begin
            cb(($urandom % 10) != 0, ($urandom % 20) == 0, 8'($urandom),
               ($urandom % 10) < 7, ($urandom % 150) == 0);
            ce();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
